count_limit_monitor: RTL and testbench

- Parametrised up/down counter with a built-in limit monitor; the generalised, sequential successor of the fixed ">99" detector used on the 7-bit display-count path.
- Holds the count itself; flags values above LIMIT; wraps or saturates at LIMIT depending on MODE.
- Issues single-cycle overflow/underflow pulses plus a sticky error flag for the display/control FSM.

---
 rtl/count_limit_pkg.sv | 13 +
 rtl/count_limit_monitor_limit_compare.sv | 14 +
 rtl/count_limit_monitor.sv | 135 +++++++++++++
 tb/tb_count_limit_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_limit_pkg.sv
// Shared FSM encodings and mode constants for the count/limit monitor.
package count_limit_pkg;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_SAT = 2'd1,
        S_ERR = 2'd2
    } state_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/count_limit_monitor_limit_compare.sv
// Combinational "value exceeds LIMIT" detector; replaces the old hand-built >99 gate tree.
module limit_compare #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 99
) (
    input  logic [WIDTH-1:0] value,
    output logic             gt
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    assign gt = (value > LIMIT_W);

endmodule

// File: rtl/count_limit_monitor.sv
// Up/down counter with LIMIT monitoring: wrap or saturate at LIMIT, one-cycle
// overflow/underflow pulses and a sticky error flag for out-of-range loads.
module count_limit_monitor
    import count_limit_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int LIMIT = 99,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             above_limit,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             err_sticky,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             above_reg, above_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             err_reg, err_next;
    logic             load_illegal;

    // above_limit is derived from the next count so it lands on the same edge as count.
    limit_compare #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_next_cmp (
        .value (count_next),
        .gt    (above_next)
    );

    limit_compare #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_load_cmp (
        .value (load_val),
        .gt    (load_illegal)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        err_next   = err_reg;

        if (clear) begin
            count_next = '0;
            state_next = S_RUN;
            err_next   = 1'b0;
        end else if (load) begin
            count_next = load_val;
            err_next   = load_illegal;
            state_next = load_illegal ? S_ERR : S_RUN;
        end else if (inc ^ dec) begin
            case (state_reg)
                S_ERR: begin
                    // Leaving the error state recovers the count but keeps err_sticky.
                    state_next = S_RUN;
                    if (inc) begin
                        count_next = '0;
                        ovf_next   = 1'b1;
                    end else begin
                        count_next = LIMIT_W;
                        unf_next   = 1'b1;
                    end
                end
                S_SAT: begin
                    if (inc) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = LIMIT_W - ONE_W;
                        state_next = S_RUN;
                    end
                end
                default: begin
                    if (inc) begin
                        if (count_reg < LIMIT_W) begin
                            count_next = count_reg + ONE_W;
                        end else begin
                            ovf_next = 1'b1;
                            if (MODE == MODE_WRAP) begin
                                count_next = '0;
                            end else begin
                                state_next = S_SAT;
                            end
                        end
                    end else begin
                        if (count_reg != '0) begin
                            count_next = count_reg - ONE_W;
                        end else begin
                            unf_next = 1'b1;
                            if (MODE == MODE_WRAP) begin
                                count_next = LIMIT_W;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RUN;
            count_reg <= '0;
            above_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            above_reg <= above_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            err_reg   <= err_next;
        end
    end

    assign count       = count_reg;
    assign above_limit = above_reg;
    assign ovf_pulse   = ovf_reg;
    assign unf_pulse   = unf_reg;
    assign err_sticky  = err_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_count_limit_monitor.sv
// Drives a wrap-mode and a saturate-mode monitor side by side and checks both
// against a behavioural model built from the counting rules.
module tb_count_limit_monitor;

    localparam int W   = 7;
    localparam int LIM = 99;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         inc = 1'b0;
    logic         dec = 1'b0;

    logic [W-1:0] count_o [2];
    logic         above_o [2];
    logic         ovf_o   [2];
    logic         unf_o   [2];
    logic         err_o   [2];
    logic [1:0]   state_o [2];

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per DUT (index 0 = wrap, 1 = saturate).
    int m_count [2];
    int m_state [2];
    bit m_err   [2];
    bit m_ovf   [2];
    bit m_unf   [2];

    always #5 clk = ~clk;

    count_limit_monitor #(.WIDTH(W), .LIMIT(LIM), .MODE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .count(count_o[0]), .above_limit(above_o[0]),
        .ovf_pulse(ovf_o[0]), .unf_pulse(unf_o[0]), .err_sticky(err_o[0]), .state(state_o[0])
    );

    count_limit_monitor #(.WIDTH(W), .LIMIT(LIM), .MODE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .count(count_o[1]), .above_limit(above_o[1]),
        .ovf_pulse(ovf_o[1]), .unf_pulse(unf_o[1]), .err_sticky(err_o[1]), .state(state_o[1])
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_state[k] = 0; m_err[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        m_ovf[k] = 0;
        m_unf[k] = 0;
        if (clear) begin
            m_count[k] = 0; m_err[k] = 0; m_state[k] = 0;
        end else if (load) begin
            m_count[k] = int'(load_val);
            m_err[k]   = (m_count[k] > LIM);
            m_state[k] = m_err[k] ? 2 : 0;
        end else if (inc != dec) begin
            if (m_state[k] == 2) begin
                m_count[k] = inc ? 0 : LIM;
                m_ovf[k] = inc;
                m_unf[k] = dec;
                m_state[k] = 0;
            end else if (inc) begin
                if (m_count[k] < LIM) m_count[k] = m_count[k] + 1;
                else begin
                    m_ovf[k] = 1;
                    if (k == 0) m_count[k] = 0;
                    else m_state[k] = 1;
                end
            end else begin
                if (m_count[k] > 0) begin
                    m_count[k] = m_count[k] - 1;
                    m_state[k] = 0;
                end else begin
                    m_unf[k] = 1;
                    if (k == 0) m_count[k] = LIM;
                end
            end
        end
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit i, input bit d);
        clear = c; load = l; load_val = W'(lv); inc = i; dec = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (count_o[k] !== '0 || above_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 ||
                unf_o[k] !== 1'b0 || err_o[k] !== 1'b0 || state_o[k] !== 2'd0) begin
                errors++;
                $display("FAIL reset dut%0d got count=%0d above=%b ovf=%b unf=%b err=%b state=%0d want all zero",
                         k, count_o[k], above_o[k], ovf_o[k], unf_o[k], err_o[k], state_o[k]);
            end
        end
        #10 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (count_o[k] !== '0 || ovf_o[k] !== 1'b0 || unf_o[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_release dut%0d got count=%0d ovf=%b unf=%b want 0 0 0",
                             k, count_o[k], ovf_o[k], unf_o[k]);
                end
            end
        end
    endtask

    task automatic test_count_up();
        drive(0, 0, 0, 1, 0);
        for (int n = 1; n <= 104; n++) begin
            if (n == 103) drive(0, 0, 0, 0, 1);
            if (n == 104) drive(0, 0, 0, 0, 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (count_o[k] !== W'(m_count[k]) || ovf_o[k] !== m_ovf[k] ||
                    unf_o[k] !== m_unf[k] || state_o[k] !== 2'(m_state[k]) ||
                    above_o[k] !== (m_count[k] > LIM)) begin
                    errors++;
                    $display("FAIL count_up step%0d dut%0d got count=%0d ovf=%b state=%0d want count=%0d ovf=%b state=%0d",
                             n, k, count_o[k], ovf_o[k], state_o[k], m_count[k], m_ovf[k], m_state[k]);
                end
            end
            if (n == 99) begin
                checks++;
                if (count_o[0] !== 7'd99 || above_o[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL count_up_99 got count=%0d above=%b want 99 0", count_o[0], above_o[0]);
                end
            end
            if (n == 102) begin
                checks++;
                if (count_o[1] !== 7'd99 || ovf_o[1] !== 1'b1 || state_o[1] !== 2'd1) begin
                    errors++;
                    $display("FAIL sat_hold got count=%0d ovf=%b state=%0d want 99 1 1",
                             count_o[1], ovf_o[1], state_o[1]);
                end
            end
        end
    endtask

    task automatic test_underflow_and_cancel();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1); tick();
        checks++;
        if (count_o[0] !== 7'd99 || unf_o[0] !== 1'b1 || count_o[1] !== 7'd0 || unf_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL underflow got wrap=%0d/%b sat=%0d/%b want 99/1 0/1",
                     count_o[0], unf_o[0], count_o[1], unf_o[1]);
        end
        drive(0, 1, 50, 0, 0); tick();
        drive(0, 0, 0, 1, 1); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (count_o[k] !== 7'd50 || ovf_o[k] !== 1'b0 || unf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL inc_dec_cancel dut%0d got count=%0d ovf=%b unf=%b want 50 0 0",
                         k, count_o[k], ovf_o[k], unf_o[k]);
            end
        end
    endtask

    task automatic test_error_load();
        for (int step = 0; step < 5; step++) begin
            case (step)
                0: drive(0, 1, 120, 0, 0);
                1: drive(0, 0, 0, 1, 0);
                2: drive(0, 1, 10, 0, 0);
                3: drive(0, 1, 127, 0, 0);
                default: drive(0, 0, 0, 0, 1);
            endcase
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (count_o[k] !== W'(m_count[k]) || above_o[k] !== (m_count[k] > LIM) ||
                    err_o[k] !== m_err[k] || state_o[k] !== 2'(m_state[k]) ||
                    ovf_o[k] !== m_ovf[k] || unf_o[k] !== m_unf[k]) begin
                    errors++;
                    $display("FAIL error_load step%0d dut%0d got count=%0d above=%b err=%b state=%0d ovf=%b unf=%b want %0d %b %b %0d %b %b",
                             step, k, count_o[k], above_o[k], err_o[k], state_o[k], ovf_o[k], unf_o[k],
                             m_count[k], m_count[k] > LIM, m_err[k], m_state[k], m_ovf[k], m_unf[k]);
                end
            end
        end
    endtask

    task automatic test_clear_priority();
        drive(0, 1, 120, 0, 0); tick();
        drive(0, 1, 77, 0, 0); tick();
        drive(1, 1, 120, 1, 0); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (count_o[k] !== '0 || above_o[k] !== 1'b0 || err_o[k] !== 1'b0 ||
                ovf_o[k] !== 1'b0 || unf_o[k] !== 1'b0 || state_o[k] !== 2'd0) begin
                errors++;
                $display("FAIL clear_priority dut%0d got count=%0d above=%b err=%b ovf=%b state=%0d want all zero",
                         k, count_o[k], above_o[k], err_o[k], ovf_o[k], state_o[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 40, 0, 0); tick();
        drive(0, 0, 0, 1, 0); tick(); tick();
        checks++;
        if (count_o[0] !== 7'd42) begin
            errors++;
            $display("FAIL pre_reset_count got %0d want 42", count_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (count_o[k] !== '0 || above_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 || state_o[k] !== 2'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d got count=%0d above=%b ovf=%b state=%0d want 0 0 0 0",
                         k, count_o[k], above_o[k], ovf_o[k], state_o[k]);
            end
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (count_o[k] !== '0 || ovf_o[k] !== 1'b0 || unf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset dut%0d got count=%0d ovf=%b unf=%b want 0 0 0",
                         k, count_o[k], ovf_o[k], unf_o[k]);
            end
        end
    endtask

    task automatic test_boundary_sweep();
        for (int v = 0; v < 128; v++) begin
            drive(0, 1, v, 0, 0);
            tick();
            checks++;
            if (count_o[0] !== W'(v) || above_o[0] !== (v > LIM) || above_o[1] !== (v > LIM)) begin
                errors++;
                $display("FAIL sweep v=%0d got count=%0d above=%b/%b want %0d %b",
                         v, count_o[0], above_o[0], above_o[1], v, v > LIM);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (count_o[k] !== W'(m_count[k]) || above_o[k] !== (m_count[k] > LIM) ||
                    ovf_o[k] !== m_ovf[k] || unf_o[k] !== m_unf[k] ||
                    err_o[k] !== m_err[k] || state_o[k] !== 2'(m_state[k])) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got count=%0d above=%b ovf=%b unf=%b err=%b state=%0d want %0d %b %b %b %b %0d",
                             n, k, count_o[k], above_o[k], ovf_o[k], unf_o[k], err_o[k], state_o[k],
                             m_count[k], m_count[k] > LIM, m_ovf[k], m_unf[k], m_err[k], m_state[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_underflow_and_cancel();
        test_error_load();
        test_clear_priority();
        test_async_reset();
        test_boundary_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
